// File: rtl/fifo_axis_reader.sv
// fifo_axis_reader: pops words from a synchronous FIFO and presents them as a
// registered valid/ready stream framed into PACKET_LEN-beat packets. A flush
// request pads a partially filled packet with null beats (keep=0) so it closes.
module fifo_axis_reader #(
    parameter int T_DATA_WIDTH = 1,
    parameter int PACKET_LEN   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    empty_i,
    input  logic [T_DATA_WIDTH-1:0] read_data_i,
    output logic                    pop_o,
    input  logic                    flush_i,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic                    m_last_o,
    output logic                    m_keep_o
);

    localparam int CNT_W = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PACKET_LEN - 1);

    typedef enum logic {
        ST_RUN,
        ST_PAD
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [CNT_W-1:0]        beat_cnt;
    logic                    slot_free;
    logic                    at_end;
    logic                    load;
    logic [T_DATA_WIDTH-1:0] load_data;
    logic                    load_keep;
    logic                    load_last;

    assign slot_free = !m_valid_o || m_ready_i;
    assign at_end    = (beat_cnt == LAST_BEAT);

    // Decide what (if anything) enters the output register this cycle and
    // where the FSM goes; a real FIFO word always wins over padding, so
    // queued data drains before a flush can take effect.
    always_comb begin
        next_state = state;
        pop_o      = 1'b0;
        load       = 1'b0;
        load_data  = '0;
        load_keep  = 1'b0;
        load_last  = 1'b0;
        case (state)
            ST_RUN: begin
                if (!empty_i && slot_free) begin
                    pop_o     = 1'b1;
                    load      = 1'b1;
                    load_data = read_data_i;
                    load_keep = 1'b1;
                    load_last = at_end;
                end else if (flush_i && empty_i && (beat_cnt != '0) && slot_free) begin
                    load      = 1'b1;
                    load_last = at_end;
                    if (!at_end) begin
                        next_state = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_last = at_end;
                    if (at_end) begin
                        next_state = ST_RUN;
                    end
                end
            end
            default: next_state = ST_RUN;
        endcase
        if (!rst_n) begin
            pop_o = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= next_state;
        end
    end

    // Beat position within the packet; wraps when the closing beat is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (load) begin
            if (load_last) begin
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

    // Output register: replaced on load, emptied when consumed with nothing new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data_o  <= '0;
            m_valid_o <= 1'b0;
            m_last_o  <= 1'b0;
            m_keep_o  <= 1'b0;
        end else if (load) begin
            m_data_o  <= load_data;
            m_valid_o <= 1'b1;
            m_last_o  <= load_last;
            m_keep_o  <= load_keep;
        end else if (slot_free) begin
            m_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_axis_reader.sv
// tb_fifo_axis_reader: directed bench with a simple FIFO model feeding the
// reader and a negedge monitor recording every accepted output beat.
module tb_fifo_axis_reader;

    localparam int W  = 8;
    localparam int PL = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         empty_i;
    logic [W-1:0] read_data_i;
    logic         pop_o;
    logic         flush_i;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;
    logic         m_keep;

    logic [7:0] words [0:255];
    logic [7:0] wr_ptr;
    logic [7:0] rd_ptr;

    logic [7:0] out_data [0:63];
    logic       out_keep [0:63];
    logic       out_last [0:63];
    int         out_cyc  [0:63];
    int         out_cnt = 0;
    int         pop_cnt = 0;
    int         cyc = 0;
    logic       pop_empty_seen = 1'b0;

    int checks = 0;
    int failures = 0;

    fifo_axis_reader #(.T_DATA_WIDTH(W), .PACKET_LEN(PL)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .empty_i(empty_i),
        .read_data_i(read_data_i),
        .pop_o(pop_o),
        .flush_i(flush_i),
        .m_data_o(m_data),
        .m_valid_o(m_valid),
        .m_ready_i(m_ready),
        .m_last_o(m_last),
        .m_keep_o(m_keep)
    );

    always #5 clk = ~clk;

    assign empty_i     = (rd_ptr == wr_ptr);
    assign read_data_i = words[rd_ptr];

    // FIFO model read side; shares the reset so it empties with the reader.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= wr_ptr;
        end else if (pop_o) begin
            rd_ptr <= rd_ptr + 8'd1;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Record accepted beats and pops in the quiet half of the cycle.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready && out_cnt < 64) begin
            out_data[out_cnt] <= m_data;
            out_keep[out_cnt] <= m_keep;
            out_last[out_cnt] <= m_last;
            out_cyc[out_cnt]  <= cyc;
            out_cnt           <= out_cnt + 1;
        end
        if (rst_n && pop_o) begin
            pop_cnt <= pop_cnt + 1;
        end
        if (pop_o && empty_i) begin
            pop_empty_seen <= 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        words[wr_ptr] = v;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic wait_out(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            if (out_cnt >= target) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        m_ready = 1'b0;
        flush_i = 1'b0;
        repeat (3) step();
        checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", m_valid); end
        checks++; if (m_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_data: got %h expected 00", m_data); end
        checks++; if (m_last !== 1'b0) begin failures++; $display("[TB] FAIL reset_last: got %b expected 0", m_last); end
        checks++; if (m_keep !== 1'b0) begin failures++; $display("[TB] FAIL reset_keep: got %b expected 0", m_keep); end
        checks++; if (pop_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_pop: got %b expected 0", pop_o); end
        rst_n = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_framing();
        int base;
        bit ok;
        logic exp_l;
        base    = out_cnt;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(8'(16 + i));
        #1;
        checks++; if (pop_o !== 1'b1) begin failures++; $display("[TB] FAIL framing_pop_same_cycle: got %b expected 1", pop_o); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL framing_valid_before_edge: got %b expected 0", m_valid); end
        step();
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h10) begin failures++; $display("[TB] FAIL framing_first_beat: got v=%b d=%h expected v=1 d=10", m_valid, m_data); end
        wait_out(base + 8, 30, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL framing_timeout: got %0d beats expected 8", out_cnt - base); end
        for (int i = 0; i < 8; i++) begin
            exp_l = (i == 3 || i == 7);
            checks++;
            if (out_data[base+i] !== 8'(16 + i) || out_keep[base+i] !== 1'b1 || out_last[base+i] !== exp_l) begin
                failures++;
                $display("[TB] FAIL framing_beat%0d: got d=%h k=%b l=%b expected d=%h k=1 l=%b", i, out_data[base+i], out_keep[base+i], out_last[base+i], 8'(16 + i), exp_l);
            end
            if (i > 0) begin
                checks++;
                if (out_cyc[base+i] - out_cyc[base+i-1] !== 1) begin
                    failures++;
                    $display("[TB] FAIL framing_gap%0d: got %0d cycles expected 1", i, out_cyc[base+i] - out_cyc[base+i-1]);
                end
            end
        end
        repeat (2) step();
    endtask

    task automatic test_backpressure();
        int base;
        bit ok;
        bit seen;
        logic exp_l;
        base    = out_cnt;
        m_ready = 1'b1;
        seen    = 1'b0;
        for (int i = 0; i < 8; i++) push(8'(16 + i));
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (m_valid === 1'b1 && m_data === 8'h11) seen = 1'b1;
        end
        checks++; if (seen !== 1'b1) begin failures++; $display("[TB] FAIL bp_reach_11: got d=%h expected 11", m_data); end
        m_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pop_o !== 1'b0 || m_valid !== 1'b1 || m_data !== 8'h11 || m_last !== 1'b0) begin
                failures++;
                $display("[TB] FAIL bp_hold%0d: got p=%b v=%b d=%h l=%b expected p=0 v=1 d=11 l=0", i, pop_o, m_valid, m_data, m_last);
            end
            step();
        end
        m_ready = 1'b1;
        wait_out(base + 8, 30, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL bp_timeout: got %0d beats expected 8", out_cnt - base); end
        for (int i = 0; i < 8; i++) begin
            exp_l = (i == 3 || i == 7);
            checks++;
            if (out_data[base+i] !== 8'(16 + i) || out_last[base+i] !== exp_l) begin
                failures++;
                $display("[TB] FAIL bp_beat%0d: got d=%h l=%b expected d=%h l=%b", i, out_data[base+i], out_last[base+i], 8'(16 + i), exp_l);
            end
        end
        repeat (3) step();
        checks++; if (out_cnt !== base + 8) begin failures++; $display("[TB] FAIL bp_no_dup: got %0d beats expected 8", out_cnt - base); end
    endtask

    task automatic test_flush_pad();
        int base;
        bit ok;
        base    = out_cnt;
        m_ready = 1'b1;
        push(8'h20);
        push(8'h21);
        wait_out(base + 2, 20, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL flush_drain_timeout: got %0d beats expected 2", out_cnt - base); end
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        wait_out(base + 4, 20, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL flush_pad_timeout: got %0d beats expected 4", out_cnt - base); end
        checks++; if (out_data[base] !== 8'h20 || out_keep[base] !== 1'b1 || out_last[base] !== 1'b0) begin failures++; $display("[TB] FAIL flush_b0: got d=%h k=%b l=%b expected 20 1 0", out_data[base], out_keep[base], out_last[base]); end
        checks++; if (out_data[base+1] !== 8'h21 || out_keep[base+1] !== 1'b1 || out_last[base+1] !== 1'b0) begin failures++; $display("[TB] FAIL flush_b1: got d=%h k=%b l=%b expected 21 1 0", out_data[base+1], out_keep[base+1], out_last[base+1]); end
        checks++; if (out_data[base+2] !== 8'h00 || out_keep[base+2] !== 1'b0 || out_last[base+2] !== 1'b0) begin failures++; $display("[TB] FAIL flush_pad0: got d=%h k=%b l=%b expected 00 0 0", out_data[base+2], out_keep[base+2], out_last[base+2]); end
        checks++; if (out_data[base+3] !== 8'h00 || out_keep[base+3] !== 1'b0 || out_last[base+3] !== 1'b1) begin failures++; $display("[TB] FAIL flush_pad1: got d=%h k=%b l=%b expected 00 0 1", out_data[base+3], out_keep[base+3], out_last[base+3]); end
        checks++; if (out_cyc[base+3] - out_cyc[base+2] !== 1) begin failures++; $display("[TB] FAIL flush_pad_gap: got %0d cycles expected 1", out_cyc[base+3] - out_cyc[base+2]); end
        repeat (3) step();
        checks++; if (m_valid !== 1'b0 || out_cnt !== base + 4) begin failures++; $display("[TB] FAIL flush_idle_after: got v=%b beats=%0d expected v=0 beats=4", m_valid, out_cnt - base); end
        base = out_cnt;
        for (int i = 0; i < 4; i++) push(8'(64 + i));
        wait_out(base + 4, 20, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL flush_next_timeout: got %0d beats expected 4", out_cnt - base); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_data[base+i] !== 8'(64 + i) || out_keep[base+i] !== 1'b1 || out_last[base+i] !== (i == 3)) begin
                failures++;
                $display("[TB] FAIL flush_next%0d: got d=%h k=%b l=%b expected d=%h k=1 l=%b", i, out_data[base+i], out_keep[base+i], out_last[base+i], 8'(64 + i), (i == 3));
            end
        end
        repeat (2) step();
    endtask

    task automatic test_flush_ignored();
        int base;
        bit ok;
        base    = out_cnt;
        m_ready = 1'b1;
        flush_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL ign_idle%0d: got v=%b expected 0", i, m_valid); end
        end
        flush_i = 1'b0;
        checks++; if (out_cnt !== base) begin failures++; $display("[TB] FAIL ign_no_beats: got %0d beats expected 0", out_cnt - base); end
        push(8'h50);
        wait_out(base + 1, 20, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL ign_first_timeout: got %0d beats expected 1", out_cnt - base); end
        push(8'h51);
        push(8'h52);
        push(8'h53);
        flush_i = 1'b1;
        wait_out(base + 4, 20, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL ign_drain_timeout: got %0d beats expected 4", out_cnt - base); end
        repeat (4) step();
        flush_i = 1'b0;
        checks++; if (out_cnt !== base + 4) begin failures++; $display("[TB] FAIL ign_no_pad: got %0d beats expected 4", out_cnt - base); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_data[base+i] !== 8'(80 + i) || out_keep[base+i] !== 1'b1 || out_last[base+i] !== (i == 3)) begin
                failures++;
                $display("[TB] FAIL ign_beat%0d: got d=%h k=%b l=%b expected d=%h k=1 l=%b", i, out_data[base+i], out_keep[base+i], out_last[base+i], 8'(80 + i), (i == 3));
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        int base;
        int pbase;
        bit ok;
        base    = out_cnt;
        pbase   = pop_cnt;
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'(96 + i));
        repeat (5) step();
        checks++; if (pop_cnt - pbase !== 1) begin failures++; $display("[TB] FAIL b2b_one_pop: got %0d pops expected 1", pop_cnt - pbase); end
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h60) begin failures++; $display("[TB] FAIL b2b_held: got v=%b d=%h expected v=1 d=60", m_valid, m_data); end
        m_ready = 1'b1;
        wait_out(base + 8, 30, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL b2b_timeout: got %0d beats expected 8", out_cnt - base); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_data[base+i] !== 8'(96 + i) || out_last[base+i] !== (i == 3 || i == 7)) begin
                failures++;
                $display("[TB] FAIL b2b_beat%0d: got d=%h l=%b expected d=%h l=%b", i, out_data[base+i], out_last[base+i], 8'(96 + i), (i == 3 || i == 7));
            end
            if (i > 0) begin
                checks++;
                if (out_cyc[base+i] - out_cyc[base+i-1] !== 1) begin
                    failures++;
                    $display("[TB] FAIL b2b_gap%0d: got %0d cycles expected 1", i, out_cyc[base+i] - out_cyc[base+i-1]);
                end
            end
        end
        repeat (2) step();
        checks++; if (pop_empty_seen !== 1'b0) begin failures++; $display("[TB] FAIL pop_while_empty: got %b expected 0", pop_empty_seen); end
    endtask

    task automatic test_reset_mid();
        int base;
        bit ok;
        base    = out_cnt;
        m_ready = 1'b1;
        push(8'h70);
        push(8'h71);
        wait_out(base + 2, 20, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL rmid_pre_timeout: got %0d beats expected 2", out_cnt - base); end
        m_ready = 1'b0;
        push(8'h72);
        repeat (2) step();
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h72) begin failures++; $display("[TB] FAIL rmid_inflight: got v=%b d=%h expected v=1 d=72", m_valid, m_data); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || m_data !== 8'h00 || m_last !== 1'b0 || m_keep !== 1'b0 || pop_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rmid_async_clear: got v=%b d=%h l=%b k=%b p=%b expected all 0", m_valid, m_data, m_last, m_keep, pop_o);
        end
        repeat (2) step();
        rst_n = 1'b1;
        step();
        base    = out_cnt;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(8'(48 + i));
        wait_out(base + 4, 20, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL rmid_post_timeout: got %0d beats expected 4", out_cnt - base); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_data[base+i] !== 8'(48 + i) || out_keep[base+i] !== 1'b1 || out_last[base+i] !== (i == 3)) begin
                failures++;
                $display("[TB] FAIL rmid_beat%0d: got d=%h k=%b l=%b expected d=%h k=1 l=%b", i, out_data[base+i], out_keep[base+i], out_last[base+i], 8'(48 + i), (i == 3));
            end
        end
        repeat (2) step();
    endtask

    initial begin
        wr_ptr  = 8'd0;
        rst_n   = 1'b0;
        m_ready = 1'b0;
        flush_i = 1'b0;
        for (int i = 0; i < 256; i++) words[i] = 8'h00;
        test_reset();
        test_framing();
        test_backpressure();
        test_flush_pad();
        test_flush_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
